mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped transmit peripheral on the core's data-memory bus, downstream of top's MemWrite/DataAdr/WriteData.
//  Stores to TX_DATA enqueue a byte into an 8-deep FIFO; a serializer drives 8N1 UART frames on tx.
//  A STATUS word is readable and clearable, so test programs print results instead of the bench decoding raw stores.
// PARAMETERS
//  BASE_ADDR     32'h0000_0100  word-aligned base; TX_DATA = BASE+0, STATUS = BASE+4
//  CLKS_PER_BIT  16             clk cycles per UART bit; >= 2
//  FIFO_DEPTH    8              entries; power of two, >= 2
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  MemWrite   in   1   store strobe from core
//  DataAdr    in   32  byte address from core
//  WriteData  in   32  store data from core
//  ReadData   out  32  STATUS read data (combinational)
//  Hit        out  1   DataAdr in [BASE, BASE+7] (combinational)
//  tx         out  1   UART serial line, idle high
// BEHAVIOUR
//  Reset (async, immediate): tx=1, FIFO empty, FSM=IDLE, overflow=0, baud/bit counters=0; applies mid-frame too.
//  Decode: only DataAdr==BASE (TX_DATA) and DataAdr==BASE+4 (STATUS) are registers; other offsets ignored, read 0.
//  Push: MemWrite && DataAdr==BASE at posedge -> WriteData[7:0] enqueued; upper bits ignored.
//  Full: push while full and no pop that cycle -> byte dropped, overflow sets (sticky).
//  Same-cycle push+pop when full -> push accepted; count unchanged.
//  Write to STATUS (any data) -> overflow cleared. Simultaneous overflow event and clear cannot occur (one address/cycle).
//  ReadData = {28'b0, overflow, full, !empty, busy} when DataAdr==BASE+4, else 32'b0.
//  busy = FSM != IDLE.
//  FSM states (enum in pkg): IDLE, START, DATA, STOP.
//   IDLE : tx=1; if !empty -> pop head into shift reg, -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA : tx=shift[0], LSB first; shift right every CLKS_PER_BIT; after 8 bits -> STOP.
//   STOP : tx=1 for CLKS_PER_BIT cycles -> IDLE.
//  Latency: push at edge N with FSM idle & FIFO empty -> pop at N+1, tx falls after edge N+2.
//  Frame = 10*CLKS_PER_BIT cycles; back-to-back frames have 1 IDLE cycle between STOP and next START.
//  Baud counter counts 0..CLKS_PER_BIT-1 and wraps; bit counter 0..7; FIFO pointers wrap modulo FIFO_DEPTH,
//   extra MSB distinguishes full/empty.
//  tx is registered (no glitches).
// CONFIGURATION
//  MMIO_UART_PARITY_EN defined: FSM adds PARITY state between DATA and STOP, tx = ^byte (even parity)
//   for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT.
//  Undefined: no PARITY state, 8N1 frame as above; state enum omits PARITY.
// STRUCTURE
//  mmio_uart_pkg: tx_state_t enum, TX_DATA_OFS=0 and STATUS_OFS=4 localparams, STATUS bit indices.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/dout, async active-high reset.
//  mmio_uart_tx holds decode, STATUS, overflow flag, baud/bit counters and FSM.
// TESTING
//  1 Reset held 22 ns, then idle 20 cycles -> tx=1, ReadData@BASE+4 = 32'h0, Hit=1 only at BASE..BASE+7.
//  2 Store 32'hABCD_0055 to BASE -> tx falls 2 cycles later; bench samples mid-bit, decodes 8'h55,
//    stop bit=1, frame 160 cycles (CLKS_PER_BIT=16).
//  3 Store 10 bytes 8'h01..8'h0A back-to-back -> first popped immediately, next 8 fill FIFO, 10th
//    dropped; STATUS=4'b1111; serial output 01..09 in order, 0A absent.
//  4 Store to BASE+4 after case 3 -> overflow bit 3 clears next cycle; full/busy bits unchanged.
//  5 Assert reset mid-DATA of byte 8'hF0 -> tx=1 same delta, STATUS=0 after release, no residual frame.
//  6 MMIO_UART_PARITY_EN: send 8'h07 -> parity bit=1, frame 176 cycles; 8'h03 -> parity bit=0.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
// Define MMIO_UART_PARITY_EN to add an even-parity bit to every frame.
package mmio_uart_pkg;

  localparam logic [31:0] TX_DATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS  = 32'd4;

  // Bit positions inside the STATUS word
  localparam int ST_BUSY      = 0;
  localparam int ST_NOT_EMPTY = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVERFLOW  = 3;

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered pointers; an extra pointer MSB separates full from empty.
// A push while full is accepted only when a pop frees the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX_DATA store enqueues a byte, STATUS reads/clears flags.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic              tx_sel, stat_sel;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic              busy;
  logic              baud_last;
  logic [31:0]       status;
  logic              unused_wdata;

  // Only the low byte of a TX_DATA store is transmitted
  assign unused_wdata = ^WriteData[31:8];

  assign Hit       = (DataAdr - BASE_ADDR) < 32'd8;
  assign tx_sel    = (DataAdr == BASE_ADDR + TX_DATA_OFS);
  assign stat_sel  = (DataAdr == BASE_ADDR + STATUS_OFS);
  assign push      = MemWrite && tx_sel;
  assign busy      = (state_q != IDLE);
  assign baud_last = (baud_q == BAUD_LAST);
  assign tx        = tx_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = busy;
    status[ST_NOT_EMPTY] = !fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVERFLOW]  = overflow_q;
    ReadData             = stat_sel ? status : 32'b0;
  end

  // A dropped byte is a push into a full FIFO that no pop relieves this cycle
  always_comb begin
    overflow_d = overflow_q;
    if (MemWrite && stat_sel)
      overflow_d = 1'b0;
    else if (push && fifo_full && !pop)
      overflow_d = 1'b1;
  end

`ifdef MMIO_UART_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = even_parity(fifo_dout);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    // The line is a registered image of the current state, one cycle behind it
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef MMIO_UART_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef MMIO_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a serial monitor pops and compares.
// Define MMIO_UART_PARITY_EN to exercise the parity frame.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          CPB  = 16;
`ifdef MMIO_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        tx;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          rst_cnt  = 0;
  logic [7:0]  exp_q [$];
  int          fall_q [$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .tx        (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge reset) rst_cnt <= rst_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the capturing posedge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    DataAdr = BASE + 32'd4;
    #1 v = ReadData;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Serial receiver: samples each bit at its midpoint, abandons the frame on any reset
  task automatic rx_frame();
    int         r0;
    logic [7:0] b;
    logic [7:0] e;
    logic       s;
    logic       p;
    r0 = rst_cnt;
    b  = '0;
    p  = 1'b0;
    fall_q.push_back(cyc);
    repeat (CPB / 2) @(negedge clk);
    if (rst_cnt != r0) return;
    check("start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      if (rst_cnt != r0) return;
      b[i] = tx;
    end
`ifdef MMIO_UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    if (rst_cnt != r0) return;
    p = tx;
`endif
    repeat (CPB) @(negedge clk);
    if (rst_cnt != r0) return;
    s = tx;
    if (exp_q.size() == 0) begin
      check("rx_unexpected", {24'b0, b}, 32'hDEAD);
    end else begin
      e = exp_q.pop_front();
      check("rx_byte", b, e);
`ifdef MMIO_UART_PARITY_EN
      check("parity_bit", p, ^e);
`endif
    end
    check("stop_bit", s, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) rx_frame();
    end
  end

  initial begin
    logic [31:0] v;
    int          sc;
    int          low_cnt;

    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    #22 reset = 1'b0;

    // Case 1: idle after reset, status clear, address window
    repeat (20) @(negedge clk);
    check("idle_tx", tx, 1'b1);
    read_status(v);
    check("reset_status", v, 32'h0);
    for (int off = -4; off < 12; off++) begin
      DataAdr = BASE + 32'(off);
      #1;
      check("hit", Hit, (off >= 0 && off < 8));
      if (off != 4) check("rd_zero", ReadData, 32'h0);
    end
    DataAdr = 32'h0;
    @(negedge clk);

    // Case 2: single byte, upper data bits ignored, two-cycle latency to start bit
    fall_q.delete();
    exp_q.push_back(8'h55);
    store(BASE, 32'hABCD_0055);
    sc = cyc;
    wait_drain(FRAME + 40);
    check("falls_case2", fall_q.size(), 1);
    if (fall_q.size() >= 1) check("tx_latency", fall_q[0] - sc, 2);
    repeat (20) @(negedge clk);

    // Case 3: ten back-to-back stores, tenth overflows
    fall_q.delete();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) exp_q.push_back(8'(i));
      store(BASE, 32'(i));
    end
    read_status(v);
    check("status_full_ovf", v, 32'hF);

    // Case 4: clearing overflow leaves full/busy/not-empty alone
    store(BASE + 32'd4, 32'h0);
    read_status(v);
    check("status_ovf_clr", v, 32'h7);
    wait_drain(9 * (FRAME + 1) + 100);
    check("falls_case3", fall_q.size(), 9);
    if (fall_q.size() >= 9) begin
      check("b2b_gap_first", fall_q[1] - fall_q[0], FRAME + 1);
      check("b2b_gap_last", fall_q[8] - fall_q[7], FRAME + 1);
    end
    repeat (20) @(negedge clk);
    read_status(v);
    check("status_drained", v, 32'h0);

    // Case 5: reset in the middle of the data bits
    exp_q.push_back(8'hF0);
    store(BASE, 32'h0000_00F0);
    repeat (60) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("tx_in_reset", tx, 1'b1);
    #19 reset = 1'b0;
    exp_q.delete();
    low_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("no_residual_frame", low_cnt, 0);
    read_status(v);
    check("status_after_reset", v, 32'h0);
    @(negedge clk);

`ifdef MMIO_UART_PARITY_EN
    // Case 6: parity 1 for 8'h07, parity 0 for 8'h03
    fall_q.delete();
    exp_q.push_back(8'h07);
    store(BASE, 32'h07);
    exp_q.push_back(8'h03);
    store(BASE, 32'h03);
    wait_drain(2 * (FRAME + 1) + 60);
    check("falls_case6", fall_q.size(), 2);
    if (fall_q.size() >= 2) check("parity_frame_len", fall_q[1] - fall_q[0], FRAME + 1);
    repeat (20) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    check("global_timeout", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
